// File: rtl/elimax_ghrd_nios_sys_pulse_pio.sv
// rtl/elimax_ghrd_nios_sys_pulse_pio.sv - Avalon-MM output PIO with per-bit level/pulse modes
// Each bit shows either its DATA level or a software-triggered pulse of PULSE_LEN cycles.
module elimax_ghrd_nios_sys_pulse_pio #(
    parameter int               WIDTH       = 8,
    parameter int               PW          = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MODE     = 3'd1;
    localparam logic [2:0] ADDR_PLEN     = 3'd2;
    localparam logic [2:0] ADDR_BUSY     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_TRIGGER  = 3'd6;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_mode;
    logic [PW-1:0]    r_plen;
    logic [PW-1:0]    r_cnt [WIDTH];

    logic             w_wr;
    logic             w_mode_wr;
    logic             w_trig_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_busy;
    logic             w_unused_wdata;

    assign w_wr      = chipselect && !write_n;
    assign w_mode_wr = w_wr && (address == ADDR_MODE);
    assign w_trig_wr = w_wr && (address == ADDR_TRIGGER);
    assign w_wdata   = writedata[WIDTH-1:0];
    assign w_unused_wdata = &{1'b0, writedata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= RESET_VALUE;
            r_mode <= '0;
            r_plen <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                case (address)
                    ADDR_DATA:     r_data <= w_wdata;
                    ADDR_MODE:     r_mode <= w_wdata;
                    ADDR_PLEN:     r_plen <= writedata[PW-1:0];
                    ADDR_OUTSET:   r_data <= r_data | w_wdata;
                    ADDR_OUTCLEAR: r_data <= r_data & ~w_wdata;
                    default: ;
                endcase
            end
            // Leaving pulse mode kills the pulse; a reload beats the final decrement.
            for (int i = 0; i < WIDTH; i++) begin
                if (w_mode_wr && !w_wdata[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_trig_wr && w_wdata[i] && r_mode[i] && (r_plen != '0)) begin
                    r_cnt[i] <= r_plen;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - PW'(1);
                end
            end
        end
    end

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_busy[i] = (r_cnt[i] != '0);
        end
    end

    assign out_port = (r_mode & w_busy) | (~r_mode & r_data);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = r_data;
            ADDR_MODE: readdata[WIDTH-1:0] = r_mode;
            ADDR_PLEN: readdata[PW-1:0]    = r_plen;
            ADDR_BUSY: readdata[WIDTH-1:0] = w_busy;
            default:   readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_elimax_ghrd_nios_sys_pulse_pio.sv
// tb/tb_elimax_ghrd_nios_sys_pulse_pio.sv - self-checking bench for the pulse PIO
// Pulses are modelled as end-cycle timestamps; outputs are compared every cycle.
module tb_elimax_ghrd_nios_sys_pulse_pio;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    elimax_ghrd_nios_sys_pulse_pio #(.WIDTH(8), .PW(16), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;

    // Reference model: a pulse on bit i is high during cycles [start, m_end[i]).
    logic [7:0]  m_data, m_mode;
    logic [15:0] m_plen;
    int          m_end [8];
    int          cyc = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data = RV;
            m_mode = 8'h00;
            m_plen = 16'h0;
            for (int i = 0; i < 8; i++) m_end[i] = 0;
        end else begin
            cyc++;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[7:0];
                    3'd1: begin
                        for (int i = 0; i < 8; i++) if (!writedata[i]) m_end[i] = 0;
                        m_mode = writedata[7:0];
                    end
                    3'd2: m_plen = writedata[15:0];
                    3'd4: m_data = m_data | writedata[7:0];
                    3'd5: m_data = m_data & ~writedata[7:0];
                    3'd6: for (int i = 0; i < 8; i++)
                        if (writedata[i] && m_mode[i] && m_plen != 16'h0) m_end[i] = cyc + int'(m_plen);
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [7:0] exp_busy();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = (cyc < m_end[i]);
        return b;
    endfunction

    function automatic logic [7:0] exp_out();
        return (m_mode & exp_busy()) | (~m_mode & m_data);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0: return {24'h0, m_data};
            3'd1: return {24'h0, m_mode};
            3'd2: return {16'h0, m_plen};
            3'd3: return {24'h0, exp_busy()};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out_port", 32'(out_port), 32'(exp_out()));
            check("model_readdata", readdata, exp_rd(address));
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        address = a; #1;
        check(name, readdata, exp);
    endtask

    int hi;

    initial begin
        // 1: reset state
        #2 reset = 1'b1;
        chk_en = 1'b1;
        #1;
        check("reset_out", 32'(out_port), 32'hA5);
        rd(3'd0, 32'hA5, "reset_data");
        rd(3'd1, 32'h0, "reset_mode");
        rd(3'd3, 32'h0, "reset_busy");
        #16 reset = 1'b0;
        idle(1);

        // 2: level writes
        wr(3'd0, 32'h0F); check("data_wr", 32'(out_port), 32'h0F);
        wr(3'd4, 32'h30); check("outset", 32'(out_port), 32'h3F);
        wr(3'd5, 32'h03); check("outclear", 32'(out_port), 32'h3C);
        rd(3'd4, 32'h0, "rd_outset");
        rd(3'd5, 32'h0, "rd_outclear");
        rd(3'd6, 32'h0, "rd_trigger");
        idle(1);

        // 3: basic pulse
        wr(3'd1, 32'h01); wr(3'd2, 32'd5); wr(3'd6, 32'h01);
        for (int k = 0; k < 5; k++) begin
            check("pulse_hi", 32'(out_port[0]), 32'h1);
            check("pulse_others", 32'(out_port[7:1]), 32'h1E);
            rd(3'd3, 32'h1, "pulse_busy");
            idle(1);
        end
        check("pulse_end", 32'(out_port), 32'h3C);
        rd(3'd3, 32'h0, "pulse_busy_end");
        idle(1);

        // 4: retrigger at cycle 3 of the pulse
        wr(3'd6, 32'h01);
        for (int k = 0; k < 2; k++) begin
            check("retrig_pre", 32'(out_port[0]), 32'h1);
            idle(1);
        end
        check("retrig_pre", 32'(out_port[0]), 32'h1);
        wr(3'd6, 32'h01);
        hi = 0;
        while (out_port[0] && hi < 20) begin hi++; idle(1); end
        check("retrig_len", 32'(hi), 32'd5);
        // retrigger on the last high cycle
        wr(3'd6, 32'h01); idle(4);
        check("last_cycle_hi", 32'(out_port[0]), 32'h1);
        wr(3'd6, 32'h01);
        hi = 0;
        while (out_port[0] && hi < 20) begin hi++; idle(1); end
        check("reload_len", 32'(hi), 32'd5);
        wr(3'd2, 32'd0); wr(3'd6, 32'h01);
        check("plen0_out", 32'(out_port[0]), 32'h0);
        rd(3'd3, 32'h0, "plen0_busy");
        idle(1);

        // 5: leave pulse mode mid-pulse
        wr(3'd2, 32'd5); wr(3'd6, 32'h01); wr(3'd0, 32'h3D);
        check("data_in_pulse", 32'(out_port), 32'h3D);
        wr(3'd1, 32'h00);
        rd(3'd3, 32'h0, "mode0_busy");
        check("mode0_out", 32'(out_port), 32'h3D);
        wr(3'd6, 32'hFF);
        check("trig_level", 32'(out_port), 32'h3D);
        rd(3'd3, 32'h0, "trig_level_busy");
        idle(1);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            address    = 3'($urandom_range(0, 7));
            chipselect = ($urandom_range(0, 4) != 0);
            write_n    = ($urandom_range(0, 3) == 0);
            case (address)
                3'd2:    writedata = $urandom_range(0, 9);
                3'd6:    writedata = $urandom & 32'h0000_01FF;
                default: writedata = $urandom;
            endcase
            @(posedge clk); #1;
            chipselect = 1'b0; write_n = 1'b1;
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end

        // 6: asynchronous reset mid-pulse
        wr(3'd1, 32'h01); wr(3'd2, 32'd6); wr(3'd6, 32'h01);
        idle(2);
        check("pre_reset_hi", 32'(out_port[0]), 32'h1);
        #3 reset = 1'b1;
        #1 check("async_reset_out", 32'(out_port), 32'hA5);
        #8 reset = 1'b0;
        idle(1);
        rd(3'd3, 32'h0, "post_reset_busy");
        check("post_reset_out", 32'(out_port), 32'hA5);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
